adc_ovfl_monitor: RTL and testbench

Parametrised successor to the single-channel ADC overflow qualifier on the receiver path. Counts overflow-flagged samples per channel over a fixed power-of-two sample window, then qualifies each window in one of two modes: mask-AND or threshold compare. Provides per-channel one-cycle pulses, sticky flags with a host clear, and the latched count from the last window for host readback. Runs in one clock domain; the caller synchronises flags into that domain beforehand.

---
 rtl/adc_ovfl_monitor.sv | 124 ++++++++++++
 tb/tb_adc_ovfl_monitor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ovfl_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : adc_ovfl_monitor
//  Purpose  : Per-channel ADC overflow counter over a 2^WIN_BITS sample
//             window, qualified by mask-AND or threshold compare.
//  Revision : 1.0
// ============================================================================
module adc_ovfl_monitor #(
  parameter int CHANNELS = 1,
  parameter int WIN_BITS = 16,
  parameter int CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_en,
  input  logic [CHANNELS-1:0]          ovfl_in,
  input  logic                         cfg_wr,
  input  logic                         cfg_mode,
  input  logic [CNT_BITS-1:0]          cfg_val,
  input  logic                         orst,
  output logic                         win_done,
  output logic [CHANNELS-1:0]          ovfl_pulse,
  output logic [CHANNELS-1:0]          ovfl_sticky,
  output logic [CHANNELS*CNT_BITS-1:0] last_cnt
);

  localparam int c_WB = (WIN_BITS > 0) ? WIN_BITS : 1;

  logic [c_WB-1:0]     r_win_ctr;
  logic                r_win_done;
  logic                r_pend_mode;
  logic [CNT_BITS-1:0] r_pend_val;
  logic                r_act_mode;
  logic [CNT_BITS-1:0] r_act_val;
  logic                r_cfg_seen;
  logic                w_term;

  // A zero-width window makes every accepted sample terminal.
  if (WIN_BITS == 0) begin : g_win_single
    assign w_term = sample_en;
  end else begin : g_win_multi
    assign w_term = sample_en && (r_win_ctr == {c_WB{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_ctr  <= '0;
      r_win_done <= 1'b0;
    end else begin
      if (sample_en) begin
        r_win_ctr <= r_win_ctr + c_WB'(1);
      end
      r_win_done <= w_term;
    end
  end

  // Active config only changes between windows, except for the very first
  // write after reset, which takes effect immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_mode <= 1'b0;
      r_pend_val  <= '0;
      r_act_mode  <= 1'b0;
      r_act_val   <= '0;
      r_cfg_seen  <= 1'b0;
    end else begin
      if (r_win_done) begin
        r_act_mode <= r_pend_mode;
        r_act_val  <= r_pend_val;
      end
      if (cfg_wr) begin
        r_pend_mode <= cfg_mode;
        r_pend_val  <= cfg_val;
        r_cfg_seen  <= 1'b1;
        if (!r_cfg_seen) begin
          r_act_mode <= cfg_mode;
          r_act_val  <= cfg_val;
        end
      end
    end
  end

  assign win_done = r_win_done;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [CNT_BITS:0]   w_sum;
    logic [CNT_BITS-1:0] w_eff;
    logic                w_qual;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] r_last;
    logic                r_pulse;
    logic                r_sticky;

    assign w_sum  = {1'b0, r_cnt} + {{CNT_BITS{1'b0}}, ovfl_in[n]};
    assign w_eff  = w_sum[CNT_BITS] ? {CNT_BITS{1'b1}} : w_sum[CNT_BITS-1:0];
    assign w_qual = r_act_mode ? ((r_act_val != '0) && (w_eff >= r_act_val))
                               : ((w_eff & r_act_val) != '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt    <= '0;
        r_last   <= '0;
        r_pulse  <= 1'b0;
        r_sticky <= 1'b0;
      end else begin
        if (sample_en) begin
          r_cnt <= w_term ? '0 : w_eff;
        end
        if (w_term) begin
          r_last <= w_eff;
        end
        r_pulse  <= w_term & w_qual;
        // A pulse arriving with orst still sets the flag.
        r_sticky <= orst ? r_pulse : (r_sticky | r_pulse);
      end
    end

    assign ovfl_pulse[n]                      = r_pulse;
    assign ovfl_sticky[n]                     = r_sticky;
    assign last_cnt[n*CNT_BITS +: CNT_BITS]   = r_last;
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_ovfl_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_ovfl_monitor
//  Purpose  : Self-checking bench for adc_ovfl_monitor.
//  Revision : 1.0
// ============================================================================
module tb_adc_ovfl_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: CHANNELS=2, WIN_BITS=3, CNT_BITS=4
  logic       a_rst = 1'b0, a_sample_en = 1'b0, a_cfg_wr = 1'b0, a_cfg_mode = 1'b0, a_orst = 1'b0;
  logic [1:0] a_ovfl_in = '0;
  logic [3:0] a_cfg_val = '0;
  logic       a_win_done;
  logic [1:0] a_ovfl_pulse, a_ovfl_sticky;
  logic [7:0] a_last_cnt;

  adc_ovfl_monitor #(.CHANNELS(2), .WIN_BITS(3), .CNT_BITS(4)) u_a (
    .clk(clk), .rst(a_rst), .sample_en(a_sample_en), .ovfl_in(a_ovfl_in),
    .cfg_wr(a_cfg_wr), .cfg_mode(a_cfg_mode), .cfg_val(a_cfg_val), .orst(a_orst),
    .win_done(a_win_done), .ovfl_pulse(a_ovfl_pulse), .ovfl_sticky(a_ovfl_sticky),
    .last_cnt(a_last_cnt)
  );

  // DUT B: CHANNELS=1, WIN_BITS=3, CNT_BITS=2
  logic       b_rst = 1'b0, b_sample_en = 1'b0, b_cfg_wr = 1'b0, b_cfg_mode = 1'b0, b_orst = 1'b0;
  logic [0:0] b_ovfl_in = '0;
  logic [1:0] b_cfg_val = '0;
  logic       b_win_done;
  logic [0:0] b_ovfl_pulse, b_ovfl_sticky;
  logic [1:0] b_last_cnt;

  adc_ovfl_monitor #(.CHANNELS(1), .WIN_BITS(3), .CNT_BITS(2)) u_b (
    .clk(clk), .rst(b_rst), .sample_en(b_sample_en), .ovfl_in(b_ovfl_in),
    .cfg_wr(b_cfg_wr), .cfg_mode(b_cfg_mode), .cfg_val(b_cfg_val), .orst(b_orst),
    .win_done(b_win_done), .ovfl_pulse(b_ovfl_pulse), .ovfl_sticky(b_ovfl_sticky),
    .last_cnt(b_last_cnt)
  );

  // DUT Z: CHANNELS=1, WIN_BITS=0, CNT_BITS=4 (every sample is terminal)
  logic       z_rst = 1'b0, z_sample_en = 1'b0, z_cfg_wr = 1'b0, z_cfg_mode = 1'b0, z_orst = 1'b0;
  logic [0:0] z_ovfl_in = '0;
  logic [3:0] z_cfg_val = '0;
  logic       z_win_done;
  logic [0:0] z_ovfl_pulse, z_ovfl_sticky;
  logic [3:0] z_last_cnt;

  adc_ovfl_monitor #(.CHANNELS(1), .WIN_BITS(0), .CNT_BITS(4)) u_z (
    .clk(clk), .rst(z_rst), .sample_en(z_sample_en), .ovfl_in(z_ovfl_in),
    .cfg_wr(z_cfg_wr), .cfg_mode(z_cfg_mode), .cfg_val(z_cfg_val), .orst(z_orst),
    .win_done(z_win_done), .ovfl_pulse(z_ovfl_pulse), .ovfl_sticky(z_ovfl_sticky),
    .last_cnt(z_last_cnt)
  );

  // Reference model for DUT A: window-level bookkeeping with plain integers.
  int         m_samples;
  int         m_ovf[2];
  bit         m_mode, m_pend_mode, m_cfg_seen;
  bit [3:0]   m_val, m_pend_val;
  bit         e_done;
  bit [1:0]   e_pulse, e_sticky;
  logic [3:0] e_last[2];

  task automatic reset_a();
    a_rst = 1'b1; a_sample_en = 1'b0; a_cfg_wr = 1'b0; a_orst = 1'b0; a_ovfl_in = '0;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    m_samples = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    m_mode = 0; m_val = 0; m_pend_mode = 0; m_pend_val = 0; m_cfg_seen = 0;
    e_done = 0; e_pulse = 0; e_sticky = 0; e_last[0] = 0; e_last[1] = 0;
  endtask

  task automatic step_a(input bit sen, input bit [1:0] ov, input bit wr,
                        input bit md, input bit [3:0] vl, input bit orst_i);
    bit term;
    int eff;
    a_sample_en = sen; a_ovfl_in = ov; a_cfg_wr = wr; a_cfg_mode = md;
    a_cfg_val = vl; a_orst = orst_i;
    @(posedge clk);
    #1;
    a_sample_en = 1'b0; a_ovfl_in = '0; a_cfg_wr = 1'b0; a_orst = 1'b0;
    term = sen && (m_samples == 7);
    e_sticky = orst_i ? e_pulse : (e_sticky | e_pulse);
    if (sen) begin
      m_samples++;
      for (int c = 0; c < 2; c++) m_ovf[c] += int'(ov[c]);
    end
    e_pulse = 2'b00;
    if (term) begin
      for (int c = 0; c < 2; c++) begin
        eff = (m_ovf[c] > 15) ? 15 : m_ovf[c];
        e_last[c] = 4'(eff);
        if (m_mode) e_pulse[c] = (m_val != 0) && (eff >= int'(m_val));
        else        e_pulse[c] = ((eff & int'(m_val)) != 0);
        m_ovf[c] = 0;
      end
      m_samples = 0;
    end
    if (e_done) begin
      m_mode = m_pend_mode; m_val = m_pend_val;
    end
    e_done = term;
    if (wr) begin
      m_pend_mode = md; m_pend_val = vl;
      if (!m_cfg_seen) begin m_mode = md; m_val = vl; end
      m_cfg_seen = 1;
    end
  endtask

  task automatic window_a(input bit [7:0] ov0, input bit [7:0] ov1);
    for (int i = 0; i < 8; i++) step_a(1'b1, {ov1[i], ov0[i]}, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic step_b(input bit sen, input bit ov, input bit wr, input bit md, input bit [1:0] vl);
    b_sample_en = sen; b_ovfl_in = ov; b_cfg_wr = wr; b_cfg_mode = md; b_cfg_val = vl;
    @(posedge clk);
    #1;
    b_sample_en = 1'b0; b_ovfl_in = '0; b_cfg_wr = 1'b0;
  endtask

  task automatic step_z(input bit sen, input bit ov, input bit wr, input bit md, input bit [3:0] vl);
    z_sample_en = sen; z_ovfl_in = ov; z_cfg_wr = wr; z_cfg_mode = md; z_cfg_val = vl;
    @(posedge clk);
    #1;
    z_sample_en = 1'b0; z_ovfl_in = '0; z_cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_a();
    b_rst = 1'b1; z_rst = 1'b1;
    @(posedge clk);
    #1 b_rst = 1'b0; z_rst = 1'b0;
    checks++; if ({a_win_done, a_ovfl_pulse, a_ovfl_sticky, a_last_cnt} !== 13'h0) begin
      failures++; $display("FAIL reset_a: got %0h expected 0", {a_win_done, a_ovfl_pulse, a_ovfl_sticky, a_last_cnt});
    end
    checks++; if ({b_win_done, b_ovfl_pulse, b_ovfl_sticky, b_last_cnt} !== 5'h0) begin
      failures++; $display("FAIL reset_b: got %0h expected 0", {b_win_done, b_ovfl_pulse, b_ovfl_sticky, b_last_cnt});
    end
    checks++; if ({z_win_done, z_ovfl_pulse, z_ovfl_sticky, z_last_cnt} !== 7'h0) begin
      failures++; $display("FAIL reset_z: got %0h expected 0", {z_win_done, z_ovfl_pulse, z_ovfl_sticky, z_last_cnt});
    end
  endtask

  task automatic test_threshold();
    reset_a();
    step_a(1'b0, 2'b00, 1'b1, 1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step_a(1'b1, {1'b0, (i == 0 || i == 3)}, 1'b0, 1'b0, 4'd0, 1'b0);
      checks++; if (a_win_done !== 1'b0) begin
        failures++; $display("FAIL thr_early_done: sample %0d got %b expected 0", i, a_win_done);
      end
    end
    step_a(1'b1, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++; if (a_win_done !== 1'b1) begin
      failures++; $display("FAIL thr_done: got %b expected 1", a_win_done);
    end
    checks++; if (a_last_cnt !== 8'h03) begin
      failures++; $display("FAIL thr_last: got %h expected 03", a_last_cnt);
    end
    checks++; if (a_ovfl_pulse !== 2'b01) begin
      failures++; $display("FAIL thr_pulse: got %b expected 01", a_ovfl_pulse);
    end
    step_a(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++; if ({a_win_done, a_ovfl_pulse, a_ovfl_sticky} !== 5'b0_00_01) begin
      failures++; $display("FAIL thr_after: got %b expected 00001", {a_win_done, a_ovfl_pulse, a_ovfl_sticky});
    end
  endtask

  task automatic test_mask();
    reset_a();
    step_a(1'b0, 2'b00, 1'b1, 1'b0, 4'b0100, 1'b0);
    window_a(8'h00, 8'b0101_0111);
    checks++; if ({a_last_cnt, a_ovfl_pulse} !== {8'h50, 2'b10}) begin
      failures++; $display("FAIL mask4: got %h/%b expected 50/10", a_last_cnt, a_ovfl_pulse);
    end
    reset_a();
    step_a(1'b0, 2'b00, 1'b1, 1'b0, 4'b1000, 1'b0);
    window_a(8'h00, 8'b0101_0111);
    checks++; if ({a_last_cnt, a_ovfl_pulse} !== {8'h50, 2'b00}) begin
      failures++; $display("FAIL mask8: got %h/%b expected 50/00", a_last_cnt, a_ovfl_pulse);
    end
  endtask

  task automatic test_disabled();
    reset_a();
    step_a(1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 1'b0);
    window_a(8'hFF, 8'hFF);
    checks++; if ({a_win_done, a_last_cnt, a_ovfl_pulse} !== {1'b1, 8'h88, 2'b00}) begin
      failures++; $display("FAIL disabled: got %b/%h/%b expected 1/88/00", a_win_done, a_last_cnt, a_ovfl_pulse);
    end
    step_a(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++; if (a_ovfl_sticky !== 2'b00) begin
      failures++; $display("FAIL disabled_sticky: got %b expected 00", a_ovfl_sticky);
    end
  endtask

  task automatic test_orst();
    reset_a();
    step_a(1'b0, 2'b00, 1'b1, 1'b1, 4'd1, 1'b0);
    window_a(8'h01, 8'h00);
    checks++; if (a_ovfl_pulse !== 2'b01) begin
      failures++; $display("FAIL orst_pulse: got %b expected 01", a_ovfl_pulse);
    end
    step_a(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++; if (a_ovfl_sticky !== 2'b01) begin
      failures++; $display("FAIL orst_with_pulse: got %b expected 01", a_ovfl_sticky);
    end
    step_a(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
    checks++; if (a_ovfl_sticky !== 2'b00) begin
      failures++; $display("FAIL orst_clear: got %b expected 00", a_ovfl_sticky);
    end
  endtask

  task automatic test_cfg_pending();
    reset_a();
    step_a(1'b0, 2'b00, 1'b1, 1'b1, 4'd15, 1'b0);
    for (int i = 0; i < 8; i++)
      step_a(1'b1, {1'b0, (i == 1 || i == 5)}, (i == 4), 1'b1, 4'd1, 1'b0);
    checks++; if ({a_win_done, a_last_cnt, a_ovfl_pulse} !== {1'b1, 8'h02, 2'b00}) begin
      failures++; $display("FAIL cfg_hold: got %b/%h/%b expected 1/02/00", a_win_done, a_last_cnt, a_ovfl_pulse);
    end
    step_a(1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    window_a(8'h10, 8'h00);
    checks++; if ({a_last_cnt, a_ovfl_pulse} !== {8'h01, 2'b01}) begin
      failures++; $display("FAIL cfg_apply: got %h/%b expected 01/01", a_last_cnt, a_ovfl_pulse);
    end
  endtask

  task automatic test_saturate();
    b_rst = 1'b1; @(posedge clk); #1 b_rst = 1'b0;
    step_b(1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 8; i++) step_b(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    checks++; if ({b_win_done, b_last_cnt, b_ovfl_pulse} !== {1'b1, 2'd3, 1'b1}) begin
      failures++; $display("FAIL sat: got %b/%0d/%b expected 1/3/1", b_win_done, b_last_cnt, b_ovfl_pulse);
    end
    for (int i = 0; i < 5; i++) step_b(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    b_rst = 1'b1; @(posedge clk); #1 b_rst = 1'b0;
    checks++; if ({b_win_done, b_last_cnt} !== 3'b0) begin
      failures++; $display("FAIL rst_mid: got %b/%0d expected 0/0", b_win_done, b_last_cnt);
    end
    step_b(1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 8; i++) begin
      step_b(1'b1, (i == 0 || i == 6), 1'b0, 1'b0, 2'd0);
      checks++; if (b_win_done !== (i == 7)) begin
        failures++; $display("FAIL rst_realign: sample %0d done got %b expected %b", i, b_win_done, (i == 7));
      end
    end
    checks++; if ({b_last_cnt, b_ovfl_pulse} !== {2'd2, 1'b0}) begin
      failures++; $display("FAIL rst_recount: got %0d/%b expected 2/0", b_last_cnt, b_ovfl_pulse);
    end
  endtask

  task automatic test_back_to_back();
    bit [2:0] pat;
    pat = 3'b101;
    z_rst = 1'b1; @(posedge clk); #1 z_rst = 1'b0;
    step_z(1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      step_z(1'b1, pat[i], 1'b0, 1'b0, 4'd0);
      checks++; if ({z_win_done, z_last_cnt, z_ovfl_pulse} !== {1'b1, 3'b000, pat[i], pat[i]}) begin
        failures++; $display("FAIL b2b: step %0d got %b/%0d/%b expected 1/%0d/%b",
                             i, z_win_done, z_last_cnt, z_ovfl_pulse, pat[i], pat[i]);
      end
    end
  endtask

  task automatic test_random();
    bit sen, wr, md, orst_i;
    bit [1:0] ov;
    bit [3:0] vl;
    reset_a();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) reset_a();
      sen    = ($urandom_range(0, 9) < 7);
      ov     = 2'($urandom_range(0, 3));
      wr     = ($urandom_range(0, 19) == 0);
      md     = 1'($urandom_range(0, 1));
      vl     = 4'($urandom_range(0, 15));
      orst_i = ($urandom_range(0, 9) == 0);
      step_a(sen, ov, wr, md, vl, orst_i);
      checks++; if ({a_win_done, a_ovfl_pulse, a_ovfl_sticky, a_last_cnt} !==
                    {e_done, e_pulse, e_sticky, e_last[1], e_last[0]}) begin
        failures++;
        $display("FAIL random: cycle %0d got done=%b pulse=%b sticky=%b last=%h expected done=%b pulse=%b sticky=%b last=%h",
                 n, a_win_done, a_ovfl_pulse, a_ovfl_sticky, a_last_cnt,
                 e_done, e_pulse, e_sticky, {e_last[1], e_last[0]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_mask();
    test_disabled();
    test_orst();
    test_cfg_pending();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
